// File: rtl/qpsk_pkg.sv
// Shared constants and state encoding for the receiver phase-sweep controller.
package qpsk_pkg;

    localparam int unsigned NPHASE         = 4;
    localparam int unsigned PHASE_W        = 2;
    localparam int unsigned DEF_WIN_LOG2   = 10;
    localparam int unsigned DEF_SETTLE     = 32;
    localparam int unsigned DEF_RELOCK_THR = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_DECIDE,
        ST_LOCKED
    } sweep_state_e;

endpackage

// File: rtl/phase_sweep_ctrl_if.sv
// Control/status bundle between the phase-sweep controller and its environment.
// master: the side that requests the sweep and feeds symbol errors; slave: the controller.
interface phase_sweep_ctrl_if
    import qpsk_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2
);

    logic                 i_enable;
    logic                 i_tick;
    logic                 i_err_r;
    logic                 i_err_i;
    logic [PHASE_W-1:0]   o_phase;
    logic                 o_enable_rx;
    logic                 o_ber_run;
    logic                 o_locked;
    logic [WIN_LOG2+1:0]  o_best_cnt;

    modport master (
        output i_enable, i_tick, i_err_r, i_err_i,
        input  o_phase, o_enable_rx, o_ber_run, o_locked, o_best_cnt
    );

    modport slave (
        input  i_enable, i_tick, i_err_r, i_err_i,
        output o_phase, o_enable_rx, o_ber_run, o_locked, o_best_cnt
    );

endinterface

// File: rtl/err_window_counter.sv
// Tick-gated symbol/error window counter with saturating error count and a
// registered one-cycle done pulse following the tick that fills the window.
module err_window_counter
    import qpsk_pkg::*;
#(
    parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                run_i,
    input  logic                tick_i,
    input  logic                err_r_i,
    input  logic                err_i_i,
    output logic [WIN_LOG2+1:0] err_cnt_o,
    output logic                done_o
);

    localparam int unsigned SYM_W = WIN_LOG2 + 1;
    localparam int unsigned ERR_W = WIN_LOG2 + 2;
    localparam int unsigned SUM_W = ERR_W + 1;
    localparam logic [SYM_W-1:0] SYM_FULL = SYM_W'(1) << WIN_LOG2;

    logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             done_q, done_d;
    logic [SYM_W-1:0] sym_base;
    logic [ERR_W-1:0] err_base;
    logic [SUM_W-1:0] err_sum;

    // Next count: clear takes effect first so a coincident tick opens the new window.
    always_comb begin
        sym_base  = clr_i ? '0 : sym_cnt_q;
        err_base  = clr_i ? '0 : err_cnt_q;
        sym_cnt_d = sym_base;
        err_cnt_d = err_base;
        done_d    = 1'b0;
        err_sum   = '0;
        if (run_i && tick_i) begin
            sym_cnt_d = sym_base + SYM_W'(1);
            err_sum   = {1'b0, err_base} + SUM_W'(err_r_i) + SUM_W'(err_i_i);
            err_cnt_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
            done_d    = (sym_cnt_d == SYM_FULL);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_cnt_q <= '0;
            err_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            sym_cnt_q <= sym_cnt_d;
            err_cnt_q <= err_cnt_d;
            done_q    <= done_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign done_o    = done_q;

endmodule

// File: rtl/phase_sweep_ctrl.sv
// Receiver sampling-phase sweep: measures the symbol error count over one window
// at each of the four phases, then locks on the lowest-error phase (lower phase
// wins ties). Optional build macro PHASE_SWEEP_RELOCK_EN keeps counting windows
// while locked and restarts the sweep when a window exceeds RELOCK_THR errors.
module phase_sweep_ctrl
    import qpsk_pkg::*;
#(
    parameter int unsigned WIN_LOG2   = DEF_WIN_LOG2,
    parameter int unsigned SETTLE     = DEF_SETTLE,
    parameter int unsigned RELOCK_THR = DEF_RELOCK_THR
) (
    input  logic              clk,
    input  logic              rst,
    phase_sweep_ctrl_if.slave bus
);

    localparam int unsigned ERR_W = WIN_LOG2 + 2;
    localparam int unsigned CNT_W = 8;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NPHASE - 1);

`ifdef PHASE_SWEEP_RELOCK_EN
    localparam bit RELOCK_ON = 1'b1;
`else
    localparam bit RELOCK_ON = 1'b0;
`endif

    sweep_state_e       state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] best_phase_q, best_phase_d;
    logic [ERR_W-1:0]   best_cnt_q, best_cnt_d;
    logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic               lock_pending_q, lock_pending_d;
    logic               enable_rx_q, enable_rx_d;
    logic               ber_run_q, ber_run_d;
    logic               locked_q, locked_d;

    logic               cnt_clr_c;
    logic               cnt_run_c;
    logic [ERR_W-1:0]   win_err;
    logic               win_done;

    err_window_counter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_err_window_counter (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr_c),
        .run_i     (cnt_run_c),
        .tick_i    (bus.i_tick),
        .err_r_i   (bus.i_err_r),
        .err_i_i   (bus.i_err_i),
        .err_cnt_o (win_err),
        .done_o    (win_done)
    );

    // Sweep sequencing, best-phase tracking and next-state of the registered outputs.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        best_phase_d   = best_phase_q;
        best_cnt_d     = best_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        lock_pending_d = lock_pending_q;
        cnt_run_c      = 1'b0;
        cnt_clr_c      = 1'b1;

        if (!bus.i_enable) begin
            state_d        = ST_IDLE;
            phase_d        = '0;
            best_phase_d   = '0;
            best_cnt_d     = '0;
            settle_cnt_d   = '0;
            lock_pending_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d        = ST_SETTLE;
                    phase_d        = '0;
                    best_phase_d   = '0;
                    best_cnt_d     = '1;
                    settle_cnt_d   = '0;
                    lock_pending_d = 1'b0;
                end
                ST_SETTLE: begin
                    if (bus.i_tick) begin
                        if (settle_cnt_q == CNT_W'(SETTLE - 1)) begin
                            settle_cnt_d   = '0;
                            lock_pending_d = 1'b0;
                            state_d        = lock_pending_q ? ST_LOCKED : ST_MEASURE;
                        end else begin
                            settle_cnt_d = settle_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_MEASURE: begin
                    cnt_run_c = 1'b1;
                    cnt_clr_c = 1'b0;
                    if (win_done) begin
                        state_d = ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    // Strict compare keeps the earlier (lower) phase on a tie.
                    if (win_err < best_cnt_q) begin
                        best_cnt_d   = win_err;
                        best_phase_d = phase_q;
                    end
                    if (phase_q == LAST_PHASE) begin
                        phase_d        = best_phase_d;
                        lock_pending_d = 1'b1;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                    settle_cnt_d = '0;
                    state_d      = ST_SETTLE;
                end
                ST_LOCKED: begin
                    if (RELOCK_ON) begin
                        cnt_run_c = 1'b1;
                        cnt_clr_c = 1'b0;
                        if (win_done) begin
                            cnt_clr_c = 1'b1;
                            if (win_err > ERR_W'(RELOCK_THR)) begin
                                state_d      = ST_SETTLE;
                                phase_d      = '0;
                                best_phase_d = '0;
                                best_cnt_d   = '1;
                                settle_cnt_d = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        enable_rx_d = (state_d != ST_IDLE);
        ber_run_d   = (state_d == ST_MEASURE) || (state_d == ST_LOCKED);
        locked_d    = (state_d == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            best_phase_q   <= '0;
            best_cnt_q     <= '0;
            settle_cnt_q   <= '0;
            lock_pending_q <= 1'b0;
            enable_rx_q    <= 1'b0;
            ber_run_q      <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            best_phase_q   <= best_phase_d;
            best_cnt_q     <= best_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            lock_pending_q <= lock_pending_d;
            enable_rx_q    <= enable_rx_d;
            ber_run_q      <= ber_run_d;
            locked_q       <= locked_d;
        end
    end

    assign bus.o_phase     = phase_q;
    assign bus.o_enable_rx = enable_rx_q;
    assign bus.o_ber_run   = ber_run_q;
    assign bus.o_locked    = locked_q;
    assign bus.o_best_cnt  = best_cnt_q;

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Directed bench for phase_sweep_ctrl: WIN_LOG2=4, SETTLE=2, RELOCK_THR=3,
// one symbol tick every 4 clocks. Per-phase window error counts come from a table.
module tb_phase_sweep_ctrl;

    localparam int unsigned WL   = 4;
    localparam int unsigned NSYM = 16;

    logic clk;
    logic rst;

    phase_sweep_ctrl_if #(.WIN_LOG2(WL)) bus ();

    phase_sweep_ctrl #(
        .WIN_LOG2   (WL),
        .SETTLE     (2),
        .RELOCK_THR (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Errors injected per measurement window, indexed by the phase being measured.
    int win_err [4];
    // Errors injected at the start of each locked period.
    int lock_err = 0;
    // Ticks delivered while the receiver is enabled and not yet locked.
    int tick_cnt = 0;

    typedef struct {
        string name;
        int    e0, e1, e2, e3;
        int    exp_phase;
        int    exp_best;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_locked(input logic val, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (bus.o_locked === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Symbol strobe and error source; errors are also driven high between ticks
    // to show they are gated by the strobe.
    initial begin
        int div  = 0;
        int widx = 0;
        int lidx = 0;
        int e;
        bus.i_tick  = 1'b0;
        bus.i_err_r = 1'b0;
        bus.i_err_i = 1'b0;
        forever begin
            step();
            if (!bus.o_ber_run) widx = 0;
            if (!bus.o_locked)  lidx = 0;
            if (div == 3) begin
                div        = 0;
                bus.i_tick = 1'b1;
                if (bus.o_enable_rx && !bus.o_locked) tick_cnt++;
                if (bus.o_locked) begin
                    bus.i_err_r = (lidx < lock_err);
                    bus.i_err_i = 1'b0;
                    lidx++;
                end else if (bus.o_ber_run) begin
                    e = win_err[bus.o_phase];
                    bus.i_err_r = (widx < e);
                    bus.i_err_i = ((widx + NSYM) < e);
                    widx++;
                end else begin
                    bus.i_err_r = 1'($urandom_range(0, 1));
                    bus.i_err_i = 1'($urandom_range(0, 1));
                end
            end else begin
                div++;
                bus.i_tick  = 1'b0;
                bus.i_err_r = 1'b1;
                bus.i_err_i = 1'b1;
            end
        end
    end

    // A phase change may only appear while the BER checkers are held off.
    initial begin
        logic [1:0] prev;
        prev = '0;
        forever begin
            step();
            if (bus.o_phase !== prev) begin
                chk("phase_change_outside_measure", bus.o_ber_run, 1'b0);
                prev = bus.o_phase;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        bit   ok;

        vecs[0] = '{"clean_phase2",   16, 16,  0, 16, 2,  0};
        vecs[1] = '{"tie_1_3",        16,  5, 16,  5, 1,  5};
        vecs[2] = '{"all_errors",     32, 32, 32, 32, 0, 32};
        vecs[3] = '{"tie_1_2_mixed",   7,  3,  3,  9, 1,  3};
        vecs[4] = '{"best_phase3",     4,  6,  8,  2, 3,  2};

        win_err[0] = 0; win_err[1] = 0; win_err[2] = 0; win_err[3] = 0;
        rst          = 1'b1;
        bus.i_enable = 1'b0;
        repeat (3) step();
        chk("rst_phase",     bus.o_phase,     0);
        chk("rst_enable_rx", bus.o_enable_rx, 0);
        chk("rst_ber_run",   bus.o_ber_run,   0);
        chk("rst_locked",    bus.o_locked,    0);
        chk("rst_best_cnt",  bus.o_best_cnt,  0);
        rst = 1'b0;
        step();

        // Full sweeps from the table.
        for (int v = 0; v < 5; v++) begin
            bus.i_enable = 1'b0;
            repeat (3) step();
            win_err[0] = vecs[v].e0;
            win_err[1] = vecs[v].e1;
            win_err[2] = vecs[v].e2;
            win_err[3] = vecs[v].e3;
            tick_cnt   = 0;
            bus.i_enable = 1'b1;
            wait_locked(1'b1, 3000, ok);
            chk({vecs[v].name, "_lock_timeout"}, 32'(ok), 1);
            chk({vecs[v].name, "_phase"},     bus.o_phase,     vecs[v].exp_phase);
            chk({vecs[v].name, "_best_cnt"},  bus.o_best_cnt,  vecs[v].exp_best);
            chk({vecs[v].name, "_enable_rx"}, bus.o_enable_rx, 1);
            chk({vecs[v].name, "_ber_run"},   bus.o_ber_run,   1);
            chk({vecs[v].name, "_ticks"},     tick_cnt,        4 * 18 + 2);
        end

        // Reset in the middle of measuring phase 2, then restart from phase 0.
        bus.i_enable = 1'b0;
        repeat (3) step();
        win_err[0] = 16; win_err[1] = 16; win_err[2] = 0; win_err[3] = 16;
        bus.i_enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (bus.o_phase == 2'd2 && bus.o_ber_run && !bus.o_locked) begin
                ok = 1'b1;
                break;
            end
        end
        chk("midrst_reach_phase2", 32'(ok), 1);
        repeat (8) step();
        rst = 1'b1;
        step();
        chk("midrst_phase",     bus.o_phase,     0);
        chk("midrst_enable_rx", bus.o_enable_rx, 0);
        chk("midrst_ber_run",   bus.o_ber_run,   0);
        chk("midrst_locked",    bus.o_locked,    0);
        chk("midrst_best_cnt",  bus.o_best_cnt,  0);
        rst = 1'b0;
        step();
        chk("restart_phase",     bus.o_phase,     0);
        chk("restart_enable_rx", bus.o_enable_rx, 1);
        chk("restart_ber_run",   bus.o_ber_run,   0);
        wait_locked(1'b1, 3000, ok);
        chk("restart_lock_timeout", 32'(ok), 1);
        chk("restart_phase_final",  bus.o_phase,    2);
        chk("restart_best_cnt",     bus.o_best_cnt, 0);

        // Drop the request while locked.
        bus.i_enable = 1'b0;
        step();
        chk("drop_locked",    bus.o_locked,    0);
        chk("drop_enable_rx", bus.o_enable_rx, 0);
        chk("drop_ber_run",   bus.o_ber_run,   0);
        chk("drop_phase",     bus.o_phase,     0);
        repeat (2) step();

        // Errors after lock: relock build restarts the sweep, default build holds lock.
        lock_err     = 4;
        bus.i_enable = 1'b1;
        wait_locked(1'b1, 3000, ok);
        chk("relock_first_lock", 32'(ok), 1);
        chk("relock_first_phase", bus.o_phase, 2);
`ifdef PHASE_SWEEP_RELOCK_EN
        wait_locked(1'b0, 200, ok);
        chk("relock_fall",      32'(ok),         1);
        chk("relock_phase",     bus.o_phase,     0);
        chk("relock_enable_rx", bus.o_enable_rx, 1);
        chk("relock_ber_run",   bus.o_ber_run,   0);
`else
        repeat (160) step();
        chk("hold_locked",   bus.o_locked,   1);
        chk("hold_phase",    bus.o_phase,    2);
        chk("hold_best_cnt", bus.o_best_cnt, 0);
        chk("hold_ber_run",  bus.o_ber_run,  1);
`endif
        lock_err     = 0;
        bus.i_enable = 1'b0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
